fnd_scan_driver: RTL

Sequential front end for the 4-digit FND path. It converts a 14-bit binary value to four BCD digits using shift-and-add-3 (one bit per clock), then time-multiplexes those digits at a fixed refresh rate. Each refresh step presents a 2-bit digit select, the selected digit's BCD nibble and a blank flag. These outputs feed the existing BCD-to-FND decoder's digit-select and value inputs; this block is the producer end of that interface.

---
 rtl/fnd_scan_driver.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver
//    Converts a 14-bit binary value to four BCD digits (shift-and-add-3, one
//    bit per clock) and time-multiplexes the digits for the downstream
//    BCD-to-FND decoder.
//
// Ports
//    i_clk          system clock, rising edge
//    i_reset        asynchronous active-high reset
//    i_value[13:0]  binary value to display (0..9999, larger values clamp)
//    i_load         one-cycle strobe, capture and convert i_value
//    i_en           display enable
//    o_digitSelect  digit position being shown (0=ones .. 3=thousands)
//    o_bcd[3:0]     BCD nibble of the selected digit
//    o_blank        selected digit must be dark
//    o_busy         conversion in progress
//    o_overflow     last accepted value exceeded 9999
//
// State | meaning
// IDLE    | waiting for i_load, display register stable
// CONVERT | 14 shift-and-add-3 steps, display written on the last one
module fnd_scan_driver #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [13:0] i_value,
    input  logic        i_load,
    input  logic        i_en,
    output logic [1:0]  o_digitSelect,
    output logic [3:0]  o_bcd,
    output logic        o_blank,
    output logic        o_busy,
    output logic        o_overflow
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [13:0]    bin_q, bin_d;
    logic [15:0]    bcd_q, bcd_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [15:0]    disp_q, disp_d;
    logic           ovf_q, ovf_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [1:0]     sel_q, sel_d;
    logic [15:0]    adj;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            presc_q <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            presc_q <= presc_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;

        adj = bcd_q;
        for (int k = 0; k < 4; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (i_load) begin
                    if (i_value > 14'd9999) begin
                        bin_d = 14'd9999;
                        ovf_d = 1'b1;
                    end else begin
                        bin_d = i_value;
                        ovf_d = 1'b0;
                    end
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q + 4'd1;
                // The display is written only from the completed result so the
                // scan never shows a half-converted value.
                if (cnt_q == 4'd13) begin
                    disp_d  = bcd_d;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan runs independently of the converter.
    always_comb begin
        presc_d = presc_q;
        sel_d   = sel_q;
        if (i_en) begin
            if (presc_q == PRE_MAX) begin
                presc_d = '0;
                sel_d   = sel_q + 2'd1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_comb begin
        o_bcd   = disp_q[3:0];
        o_blank = 1'b0;
        case (sel_q)
            2'd0: begin
                o_bcd   = disp_q[3:0];
                o_blank = 1'b0;
            end
            2'd1: begin
                o_bcd   = disp_q[7:4];
                o_blank = (disp_q[15:4] == 12'd0);
            end
            2'd2: begin
                o_bcd   = disp_q[11:8];
                o_blank = (disp_q[15:8] == 8'd0);
            end
            default: begin
                o_bcd   = disp_q[15:12];
                o_blank = (disp_q[15:12] == 4'd0);
            end
        endcase
        if (!i_en) begin
            o_blank = 1'b1;
        end
    end

    assign o_digitSelect = sel_q;
    assign o_busy        = (state_q == CONVERT);
    assign o_overflow    = ovf_q;

endmodule
